ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage; consumes the Issue-Execute pipeline register outputs and drives the Execute-Memory pipeline register.
- Contains operand forwarding muxes, a single-cycle integer ALU/shifter, and an iterative 32-cycle multiply/divide unit with HI/LO registers.
- Asserts stall_o so upstream holds its Issue-Execute contents while a HI/LO-dependent op waits for the multiply/divide unit.

Parameters:
- MD_CYCLES, 32, iterations per multiply/divide; the counter is 5 bits and fixed at 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_i  in  1  instruction valid
- alu_op_i  in  6  operation code (encoding in Behaviour)
- alu_src_i  in  3  [0] B=sign_imm; [1] shift amount from shamt, else A[4:0]; [2] immediate is {sign_imm[15:0],16'h0}
- reg_dst_i  in  1  1: destination is rd, 0: destination is rt
- rt_i, rd_i  in  5  register specifiers
- reg_wr_i, mem_to_reg_i, mem_wr_i  in  1  control pass-through
- r_data_p1_i, r_data_p2_i  in  32  rs and rt operands
- sign_imm_i  in  32  sign-extended immediate
- shamt_i  in  6  shift amount; bits [4:0] are used
- fwd_a_sel_i, fwd_b_sel_i  in  2  00 register, 01 wb_fwd_data_i, 10 mem_fwd_data_i, 11 register
- mem_fwd_data_i, wb_fwd_data_i  in  32  forwarded results
- valid_o, reg_wr_o, mem_to_reg_o, mem_wr_o  out  1  to Execute-Memory register
- alu_result_o  out  32  ALU result or memory address
- wr_data_o  out  32  store data: forwarded B before the immediate mux
- wr_reg_o  out  5  destination register
- stall_o  out  1  hold upstream; the current op is bubbled
- md_busy_o  out  1  multiply/divide unit iterating

Behaviour:
- alu_op encoding:
  - 0x20/0x21 add (no overflow trap); 0x22/0x23 sub; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor; 0x2A slt (signed); 0x2B sltu
  - 0x00 sll, 0x02 srl, 0x03 sra; shift source is B, amount per alu_src_i[1]
  - 0x10 mfhi, 0x12 mflo, 0x11 mthi, 0x13 mtlo
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu
  - Any other code: result 0.
- Datapath and outputs:
  - alu_result_o, wr_data_o, wr_reg_o and control outputs are combinational; the only state is the FSM, 5-bit counter, 64-bit accumulator/remainder, operand/sign latches, HI and LO.
- FSM, states IDLE and BUSY:
  - IDLE->BUSY when valid_i, a mult/div op, and stall_o=0. Forwarded operands are latched; signed ops latch magnitudes plus result-sign flags; counter cleared.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle.
  - At count==31 the final step is taken and sign-corrected results are written: mult writes HI/LO = product[63:32]/[31:0]; div writes LO=quotient, HI=remainder. The FSM then returns to IDLE.
  - Op accepted in cycle T occupies BUSY cycles T+1..T+32; new HI/LO are visible from T+33.
- Result signs:
  - Signed mult: product negated if operand signs differ.
  - Signed div: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide corner cases:
  - Divide by zero: LO=0xFFFFFFFF, HI=dividend magnitude before sign fix; no exception.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- Issue of a mult/div op: the op itself writes no GPR; reg_wr_o and mem_wr_o are forced 0 and valid_o passes through.
- stall_o = md_busy_o AND valid_i AND alu_op_i is any HI/LO op (mfhi, mflo, mthi, mtlo, mult, multu, div, divu).
  - While stall_o=1: valid_o, reg_wr_o and mem_wr_o are 0 (bubble) and no architectural state changes.
- Non-HI/LO ops proceed without stall while BUSY.
- mthi/mtlo write HI/LO at the clock edge when valid and not stalled.
- Reset (asynchronous, mid-operation included): state IDLE, counter 0, HI=LO=0, accumulators 0, so md_busy_o=0 and stall_o=0. Any in-flight multiply/divide is abandoned.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: full multiply/divide unit, HI/LO registers and stall logic as above.
- Undefined:
  - No FSM and no HI/LO; md_busy_o=0, stall_o=0.
  - mult/div/mthi/mtlo behave as NOPs (reg_wr_o=0, mem_wr_o=0); mfhi/mflo return 0.
  - All other behaviour is unchanged.

Test Plan:
- ADD with A=0x7FFFFFFF, B=1 -> alu_result_o=0x80000000; alu_src_i=3'b101 with sign_imm_i=0x1234, A=0 -> 0x12340000.
- fwd_a_sel_i=10 with mem_fwd_data_i=5, B=3, op sub -> alu_result_o=2; wr_data_o equals the forwarded B even when alu_src_i[0]=1.
- MULT 0xFFFFFFFE x 3, then MFLO next cycle -> stall_o=1 for 32 cycles; valid_o=0 during the stall; then alu_result_o=0xFFFFFFFA; MFHI returns 0xFFFFFFFF.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 10/0 -> LO=0xFFFFFFFF, HI=10; an OR issued while BUSY completes with no stall.
- reset_n asserted at iteration 15 of a multiply -> md_busy_o=0 immediately; later MFHI/MFLO return 0 with no stall.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU/shifter and an iterative multiply/divide unit.
// Define EX_MULDIV_EN to build the multiply/divide unit with HI/LO and stall logic.
module ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  input  logic [5:0]  alu_op_i,
  input  logic [2:0]  alu_src_i,
  input  logic        reg_dst_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_wr_i,
  input  logic        mem_to_reg_i,
  input  logic        mem_wr_i,
  input  logic [31:0] r_data_p1_i,
  input  logic [31:0] r_data_p2_i,
  input  logic [31:0] sign_imm_i,
  input  logic [5:0]  shamt_i,
  input  logic [1:0]  fwd_a_sel_i,
  input  logic [1:0]  fwd_b_sel_i,
  input  logic [31:0] mem_fwd_data_i,
  input  logic [31:0] wb_fwd_data_i,
  output logic        valid_o,
  output logic        reg_wr_o,
  output logic        mem_to_reg_o,
  output logic        mem_wr_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] wr_data_o,
  output logic [4:0]  wr_reg_o,
  output logic        stall_o,
  output logic        md_busy_o
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CW        = 5;
  localparam int unsigned MD_CYCLES = 32;

  localparam logic [5:0] OP_SLL  = 6'h00;
  localparam logic [5:0] OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] OP_MFHI = 6'h10;
  localparam logic [5:0] OP_MTHI = 6'h11;
  localparam logic [5:0] OP_MFLO = 6'h12;
  localparam logic [5:0] OP_MTLO = 6'h13;
  localparam logic [5:0] OP_MULT = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV  = 6'h1A;
  localparam logic [5:0] OP_DIVU = 6'h1B;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SLTU = 6'h2B;

  logic [XLEN-1:0] op_a, fwd_b, imm_val, op_b, alu_result_c;
  logic [XLEN-1:0] hi_val, lo_val;
  logic [4:0]      sh_amt;
  logic            is_md, is_hilo, no_gpr, stall_c, md_busy_c;
  logic            unused_bits;

  // Operand forwarding and immediate selection
  always_comb begin
    case (fwd_a_sel_i)
      2'b01:   op_a = wb_fwd_data_i;
      2'b10:   op_a = mem_fwd_data_i;
      default: op_a = r_data_p1_i;
    endcase
    case (fwd_b_sel_i)
      2'b01:   fwd_b = wb_fwd_data_i;
      2'b10:   fwd_b = mem_fwd_data_i;
      default: fwd_b = r_data_p2_i;
    endcase
    imm_val = alu_src_i[2] ? {sign_imm_i[15:0], 16'h0000} : sign_imm_i;
    op_b    = alu_src_i[0] ? imm_val : fwd_b;
    sh_amt  = alu_src_i[1] ? shamt_i[4:0] : op_a[4:0];
  end

  // Single-cycle ALU and shifter
  always_comb begin
    alu_result_c = '0;
    case (alu_op_i)
      OP_ADD, OP_ADDU: alu_result_c = op_a + op_b;
      OP_SUB, OP_SUBU: alu_result_c = op_a - op_b;
      OP_AND:          alu_result_c = op_a & op_b;
      OP_OR:           alu_result_c = op_a | op_b;
      OP_XOR:          alu_result_c = op_a ^ op_b;
      OP_NOR:          alu_result_c = ~(op_a | op_b);
      OP_SLT:          alu_result_c = {31'h0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:         alu_result_c = {31'h0, op_a < op_b};
      OP_SLL:          alu_result_c = op_b << sh_amt;
      OP_SRL:          alu_result_c = op_b >> sh_amt;
      OP_SRA:          alu_result_c = XLEN'($signed(op_b) >>> sh_amt);
      OP_MFHI:         alu_result_c = hi_val;
      OP_MFLO:         alu_result_c = lo_val;
      default:         alu_result_c = '0;
    endcase
  end

  assign is_md   = (alu_op_i == OP_MULT) || (alu_op_i == OP_MULTU) ||
                   (alu_op_i == OP_DIV)  || (alu_op_i == OP_DIVU);
  assign is_hilo = is_md || (alu_op_i == OP_MFHI) || (alu_op_i == OP_MFLO) ||
                   (alu_op_i == OP_MTHI) || (alu_op_i == OP_MTLO);
  assign stall_c = md_busy_c & valid_i & is_hilo;

`ifdef EX_MULDIV_EN
  assign no_gpr = is_md;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} md_state_t;

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [63:0]     acc_q;
  logic [XLEN-1:0] opd_q, hi_q, lo_q;
  logic            is_div_q, neg_q_q, neg_r_q, div_zero_q;
  logic            md_start, md_last, md_signed, op_is_div;
  logic [XLEN-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic [32:0]     mul_sum, div_hi, div_trial;
  logic [63:0]     mul_next, div_next, step_next, prod_fix;

  assign md_busy_c = (state_q == S_BUSY);
  assign md_start  = valid_i & is_md & ~stall_c;
  assign md_last   = (cnt_q == CW'(MD_CYCLES - 1));
  assign md_signed = ~alu_op_i[0];
  assign op_is_div = alu_op_i[1];
  assign mag_a     = (md_signed & op_a[31])  ? -op_a  : op_a;
  assign mag_b     = (md_signed & fwd_b[31]) ? -fwd_b : fwd_b;
  assign hi_val    = hi_q;
  assign lo_val    = lo_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_start) state_d = S_BUSY;
      S_BUSY:  if (md_last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step on magnitudes
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opd_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    div_hi    = acc_q[63:31];
    div_trial = div_hi - {1'b0, opd_q};
    div_next  = div_trial[32] ? {acc_q[62:31], acc_q[30:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};
    step_next = is_div_q ? div_next : mul_next;
    prod_fix  = neg_q_q ? -step_next : step_next;
    quo_fix   = (neg_q_q && !div_zero_q) ? -step_next[31:0]  : step_next[31:0];
    rem_fix   = (neg_r_q && !div_zero_q) ? -step_next[63:32] : step_next[63:32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      if (md_start) begin
        cnt_q      <= '0;
        acc_q      <= {32'h0, op_is_div ? mag_a : mag_b};
        opd_q      <= op_is_div ? mag_b : mag_a;
        is_div_q   <= op_is_div;
        neg_q_q    <= md_signed & (op_a[31] ^ fwd_b[31]);
        neg_r_q    <= md_signed & op_a[31];
        div_zero_q <= (fwd_b == '0);
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + CW'(1);
        acc_q <= step_next;
        if (md_last) begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
        end
      end
      // Moves into HI/LO never collide with a completing op: they stall while busy
      if (valid_i && !stall_c && alu_op_i == OP_MTHI) hi_q <= op_a;
      if (valid_i && !stall_c && alu_op_i == OP_MTLO) lo_q <= op_a;
    end
  end

  assign unused_bits = shamt_i[5];
`else
  assign no_gpr      = is_hilo & ~((alu_op_i == OP_MFHI) || (alu_op_i == OP_MFLO));
  assign md_busy_c   = 1'b0;
  assign hi_val      = '0;
  assign lo_val      = '0;
  assign unused_bits = ^{shamt_i[5], clk, reset_n};
`endif

  assign alu_result_o = alu_result_c;
  assign wr_data_o    = fwd_b;
  assign wr_reg_o     = reg_dst_i ? rd_i : rt_i;
  assign valid_o      = valid_i & ~stall_c;
  assign reg_wr_o     = reg_wr_i & ~stall_c & ~no_gpr;
  assign mem_wr_o     = mem_wr_i & ~stall_c & ~no_gpr;
  assign mem_to_reg_o = mem_to_reg_i;
  assign stall_o      = stall_c;
  assign md_busy_o    = md_busy_c;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver queues expectations, monitor checks each valid output.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int S32 = MD ? 32 : 0;
  localparam int S31 = MD ? 31 : 0;

  localparam logic [5:0] SLL = 6'h00, SRL = 6'h02, SRA = 6'h03;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] ADD = 6'h20, SUB = 6'h22, AND_ = 6'h24, OR_ = 6'h25;
  localparam logic [5:0] XOR_ = 6'h26, NOR_ = 6'h27, SLT = 6'h2A, SLTU = 6'h2B;

  logic        clk, reset_n, valid_i, reg_dst_i, reg_wr_i, mem_to_reg_i, mem_wr_i;
  logic [5:0]  alu_op_i, shamt_i;
  logic [2:0]  alu_src_i;
  logic [4:0]  rt_i, rd_i, wr_reg_o;
  logic [31:0] r_data_p1_i, r_data_p2_i, sign_imm_i, mem_fwd_data_i, wb_fwd_data_i;
  logic [1:0]  fwd_a_sel_i, fwd_b_sel_i;
  logic        valid_o, reg_wr_o, mem_to_reg_o, mem_wr_o, stall_o, md_busy_o;
  logic [31:0] alu_result_o, wr_data_o;

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  wreg;
    logic        rw, mw, m2r, chk_res;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   seq = 0;

  ex_stage dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .alu_op_i(alu_op_i),
    .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i), .rt_i(rt_i), .rd_i(rd_i),
    .reg_wr_i(reg_wr_i), .mem_to_reg_i(mem_to_reg_i), .mem_wr_i(mem_wr_i),
    .r_data_p1_i(r_data_p1_i), .r_data_p2_i(r_data_p2_i), .sign_imm_i(sign_imm_i),
    .shamt_i(shamt_i), .fwd_a_sel_i(fwd_a_sel_i), .fwd_b_sel_i(fwd_b_sel_i),
    .mem_fwd_data_i(mem_fwd_data_i), .wb_fwd_data_i(wb_fwd_data_i),
    .valid_o(valid_o), .reg_wr_o(reg_wr_o), .mem_to_reg_o(mem_to_reg_o),
    .mem_wr_o(mem_wr_o), .alu_result_o(alu_result_o), .wr_data_o(wr_data_o),
    .wr_reg_o(wr_reg_o), .stall_o(stall_o), .md_busy_o(md_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every presented output consumes one queued expectation
  always @(negedge clk) begin
    if (reset_n && valid_o) begin
      if (sbq.size() == 0) begin
        check32("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk_res) check32("alu_result", alu_result_o, mon_e.res);
        check32("wr_data", wr_data_o, mon_e.wd);
        check32("wr_reg", {27'h0, wr_reg_o}, {27'h0, mon_e.wreg});
        check32("ctrl", {29'h0, reg_wr_o, mem_wr_o, mem_to_reg_o},
                {29'h0, mon_e.rw, mon_e.mw, mon_e.m2r});
      end
    end
  end

  // Drive one op, hold it through any stall, and check the number of stalled cycles
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] src, input logic [31:0] imm, input logic [5:0] sh,
                       input logic rw, input logic mw, input logic [31:0] res,
                       input logic chk, input logic erw, input int exp_stall);
    exp_t e;
    int   stalls;
    logic st;
    seq++;
    alu_op_i = op; r_data_p1_i = a; r_data_p2_i = b; alu_src_i = src;
    sign_imm_i = imm; shamt_i = sh; reg_wr_i = rw; mem_wr_i = mw;
    mem_to_reg_i = seq[0]; rd_i = seq[4:0]; rt_i = ~seq[4:0]; reg_dst_i = seq[1];
    valid_i = 1'b1;
    e.res  = res;
    e.wd   = (fwd_b_sel_i == 2'b01) ? wb_fwd_data_i :
             (fwd_b_sel_i == 2'b10) ? mem_fwd_data_i : b;
    e.wreg = seq[1] ? seq[4:0] : ~seq[4:0];
    e.rw   = erw;
    e.mw   = mw;
    e.m2r  = seq[0];
    e.chk_res = chk;
    sbq.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      st = stall_o;
      @(posedge clk);
      #1;
      if (!st) break;
      stalls++;
      if (stalls > 100) begin
        check32("stall_timeout", 32'(stalls), 32'(exp_stall));
        break;
      end
    end
    valid_i = 1'b0;
    check32("stall_cycles", 32'(stalls), 32'(exp_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; valid_i = 1'b0; alu_op_i = '0; alu_src_i = '0; reg_dst_i = 1'b0;
    rt_i = '0; rd_i = '0; reg_wr_i = 1'b0; mem_to_reg_i = 1'b0; mem_wr_i = 1'b0;
    r_data_p1_i = '0; r_data_p2_i = '0; sign_imm_i = '0; shamt_i = '0;
    fwd_a_sel_i = '0; fwd_b_sel_i = '0; mem_fwd_data_i = '0; wb_fwd_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_md_busy", {31'h0, md_busy_o}, 32'd0);
    check32("reset_stall", {31'h0, stall_o}, 32'd0);
    check32("reset_valid", {31'h0, valid_o}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU, immediate and forwarding
    issue(ADD, 32'h7FFFFFFF, 32'd1, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b1, 0);
    issue(ADD, 32'd0, 32'h55, 3'b101, 32'h1234, 6'd0, 1'b1, 1'b0, 32'h12340000, 1'b1, 1'b1, 0);
    fwd_a_sel_i = 2'b10; mem_fwd_data_i = 32'd5;
    issue(SUB, 32'h99, 32'd3, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'd2, 1'b1, 1'b1, 0);
    fwd_a_sel_i = 2'b00;
    fwd_b_sel_i = 2'b01; wb_fwd_data_i = 32'hABCD;
    issue(ADD, 32'h100, 32'h77, 3'b001, 32'd8, 6'd0, 1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 0);
    fwd_b_sel_i = 2'b00;
    issue(SLT,  32'hFFFFFFFF, 32'd1, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'd1, 1'b1, 1'b1, 0);
    issue(SLTU, 32'hFFFFFFFF, 32'd1, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 0);
    issue(SRA, 32'd0, 32'h80000000, 3'b010, 32'd0, 6'd4, 1'b1, 1'b0, 32'hF8000000, 1'b1, 1'b1, 0);
    issue(SRL, 32'h24, 32'h80000000, 3'b000, 32'd0, 6'd9, 1'b1, 1'b0, 32'h08000000, 1'b1, 1'b1, 0);
    issue(SLL, 32'd0, 32'd1, 3'b010, 32'd0, 6'h3F, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b1, 0);
    issue(NOR_, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 0);
    issue(XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'h0FF00FF0, 1'b1, 1'b1, 0);
    issue(AND_, 32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'hF000F000, 1'b1, 1'b1, 0);
    issue(6'h3F, 32'd1, 32'd2, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 0);

    // Signed multiply followed by dependent reads
    issue(MULT, 32'hFFFFFFFE, 32'd3, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    issue(MFLO, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'hFFFFFFFA : 32'd0, 1'b1, 1'b1, S32);
    issue(MFHI, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'hFFFFFFFF : 32'd0, 1'b1, 1'b1, 0);

    // Signed divide -7/2
    issue(DIV, 32'hFFFFFFF9, 32'd2, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    issue(MFLO, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'hFFFFFFFD : 32'd0, 1'b1, 1'b1, S32);
    issue(MFHI, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'hFFFFFFFF : 32'd0, 1'b1, 1'b1, 0);

    // Divide by zero with an independent op overlapping the busy period
    issue(DIVU, 32'd10, 32'd0, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    issue(OR_, 32'h0F, 32'hF0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'hFF, 1'b1, 1'b1, 0);
    issue(MFLO, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'hFFFFFFFF : 32'd0, 1'b1, 1'b1, S31);
    issue(MFHI, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'd10 : 32'd0, 1'b1, 1'b1, 0);

    // Most-negative / -1
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    issue(MFLO, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'h80000000 : 32'd0, 1'b1, 1'b1, S32);
    issue(MFHI, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 0);

    // Moves into HI/LO
    issue(MTHI, 32'h1111, 32'd0, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    issue(MTLO, 32'h2222, 32'd0, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    issue(MFHI, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'h1111 : 32'd0, 1'b1, 1'b1, 0);
    issue(MFLO, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, MD ? 32'h2222 : 32'd0, 1'b1, 1'b1, 0);

    // Reset in the middle of a multiply
    issue(MULT, 32'd5, 32'd7, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
    repeat (15) @(posedge clk);
    #1;
`ifdef EX_MULDIV_EN
    check32("busy_mid_mult", {31'h0, md_busy_o}, 32'd1);
`endif
    reset_n = 1'b0;
    alu_op_i = MFHI;
    valid_i = 1'b1;
    #1;
    check32("busy_after_reset", {31'h0, md_busy_o}, 32'd0);
    check32("stall_in_reset", {31'h0, stall_o}, 32'd0);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check32("busy_post_reset", {31'h0, md_busy_o}, 32'd0);
    issue(MFHI, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 0);
    issue(MFLO, 32'd0, 32'd0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
